// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from an internal baud counter.
// Emits one-cycle rx_valid per good byte and one-cycle rx_err on a bad stop bit.
module uart_rx #(
    parameter int unsigned CLK_FREQUENCE = 50_000_000,
    parameter int unsigned BAUD_RATE     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam int unsigned BPS_CNT  = CLK_FREQUENCE / BAUD_RATE - 1;
    localparam int unsigned HALF_CNT = BPS_CNT / 2;
    localparam int unsigned BPS_WD   = $clog2(BPS_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_c;
    logic              rx_meta;
    logic              rx_s;
    logic              rx_d;
    logic [BPS_WD-1:0] cnt;
    logic [BPS_WD-1:0] cnt_c;
    logic [2:0]        idx;
    logic [2:0]        idx_c;
    logic [7:0]        shift;
    logic [7:0]        shift_c;
    logic [7:0]        data_c;
    logic              valid_c;
    logic              err_c;
    logic              busy_c;
    logic              start_edge_c;
    logic              mid_hit_c;
    logic              bit_hit_c;

    // Two-flop synchronizer plus previous-sample flop for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign start_edge_c = rx_d & ~rx_s;
    assign mid_hit_c    = (cnt == BPS_WD'(HALF_CNT));
    assign bit_hit_c    = (cnt == BPS_WD'(BPS_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_c;
        end
    end

    always_comb begin
        state_c = state;
        case (state)
            IDLE:  if (start_edge_c) state_c = START;
            START: if (mid_hit_c) state_c = rx_s ? IDLE : DATA;
            DATA:  if (bit_hit_c && (idx == 3'd7)) state_c = STOP;
            STOP:  if (bit_hit_c) state_c = IDLE;
            default: state_c = IDLE;
        endcase
    end

    // Next values for counter, shifter and the registered outputs
    always_comb begin
        cnt_c   = '0;
        idx_c   = idx;
        shift_c = shift;
        data_c  = rx_data;
        valid_c = 1'b0;
        err_c   = 1'b0;
        busy_c  = (state_c != IDLE);
        if ((state != IDLE) && (state_c == state)) begin
            cnt_c = cnt + BPS_WD'(1);
        end
        case (state)
            START: begin
                if (mid_hit_c && !rx_s) idx_c = 3'd0;
            end
            DATA: begin
                if (bit_hit_c) begin
                    shift_c = {rx_s, shift[7:1]};
                    idx_c   = idx + 3'd1;
                    cnt_c   = '0;
                end
            end
            STOP: begin
                if (bit_hit_c) begin
                    if (rx_s) begin
                        data_c  = shift;
                        valid_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= 3'd0;
            shift    <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            cnt      <= cnt_c;
            idx      <= idx_c;
            shift    <= shift_c;
            rx_data  <= data_c;
            rx_valid <= valid_c;
            rx_err   <= err_c;
            rx_busy  <= busy_c;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks/bit: directed scenarios plus a random byte stream
// checked against a frame-level model of good bytes, errors and pulse timing.
module tb_uart_rx;

    localparam int unsigned CLK_F = 160;
    localparam int unsigned BAUD  = 10;
    localparam int unsigned BIT   = 16;
    localparam int          LAT_MIN = 155;
    localparam int          LAT_MAX = 157;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] v_data[$];
    int         v_cyc[$];
    int         e_cyc[$];
    int         both_cnt = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLK_FREQUENCE(CLK_F),
        .BAUD_RATE    (BAUD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_err  (rx_err),
        .rx_busy (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            v_data.push_back(rx_data);
            v_cyc.push_back(cyc);
        end
        if (rx_err) e_cyc.push_back(cyc);
        if (rx_valid && rx_err) both_cnt++;
    end

    task clear_mon();
        v_data.delete();
        v_cyc.delete();
        e_cyc.delete();
        both_cnt = 0;
    endtask

    task drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task send_frame(input logic [7:0] b, input logic stop, output int t_edge);
        t_edge = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rx_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task test_idle();
        int busy_seen;
        busy_seen = 0;
        clear_mon();
        rx = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (rx_busy !== 1'b0) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (v_data.size() != 0) begin errors++; $display("FAIL idle_valid: got %0d pulses expected 0", v_data.size()); end
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL idle_err: got %0d pulses expected 0", e_cyc.size()); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL idle_data: got %h expected 00", rx_data); end
    endtask

    task test_single();
        int t;
        clear_mon();
        send_frame(8'hA5, 1'b1, t);
        repeat (20) @(negedge clk);
        last_good = 8'hA5;
        checks++; if (v_data.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", v_data.size()); end
        if (v_data.size() >= 1) begin
            checks++; if (v_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", v_data[0]); end
            checks++;
            if ((v_cyc[0] - t) < LAT_MIN || (v_cyc[0] - t) > LAT_MAX) begin
                errors++; $display("FAIL single_latency: got %0d expected %0d..%0d", v_cyc[0] - t, LAT_MIN, LAT_MAX);
            end
        end
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL single_err: got %0d pulses expected 0", e_cyc.size()); end
    endtask

    task test_back_to_back();
        int t0, t1;
        clear_mon();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        repeat (20) @(negedge clk);
        last_good = 8'hFF;
        checks++; if (v_data.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", v_data.size()); end
        if (v_data.size() == 2) begin
            checks++; if (v_data[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", v_data[0]); end
            checks++; if (v_data[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", v_data[1]); end
            checks++; if ((v_cyc[1] - v_cyc[0]) != int'(10 * BIT)) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected %0d", v_cyc[1] - v_cyc[0], 10 * BIT);
            end
        end
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL b2b_err: got %0d pulses expected 0", e_cyc.size()); end
    endtask

    task test_glitch();
        int tg, last_busy, rose;
        clear_mon();
        rose      = 0;
        last_busy = -1;
        tg        = cyc;
        rx        = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 3) rx = 1'b1;
            if (rx_busy === 1'b1) begin
                rose      = 1;
                last_busy = cyc;
            end
        end
        checks++; if (rose != 1) begin errors++; $display("FAIL glitch_busy_rise: got %0d expected 1", rose); end
        checks++; if ((last_busy - tg) > 12) begin errors++; $display("FAIL glitch_busy_fall: busy until +%0d expected <= +12", last_busy - tg); end
        checks++; if (v_data.size() != 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses expected 0", v_data.size()); end
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL glitch_err: got %0d pulses expected 0", e_cyc.size()); end
    endtask

    task test_framing();
        logic [7:0] b;
        b = 8'h3C;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rx = 1'b0;
        repeat (41 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checks++; if (e_cyc.size() != 1) begin errors++; $display("FAIL framing_err_count: got %0d expected 1", e_cyc.size()); end
        checks++; if (v_data.size() != 0) begin errors++; $display("FAIL framing_valid: got %0d pulses expected 0", v_data.size()); end
        checks++; if (rx_data !== last_good) begin errors++; $display("FAIL framing_data_hold: got %h expected %h", rx_data, last_good); end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL framing_both: got %0d expected 0", both_cnt); end
    endtask

    task test_reset_mid();
        logic [7:0] b;
        int t;
        b = 8'h55;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", rx_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", rx_busy); end
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'h81, 1'b1, t);
        repeat (20) @(negedge clk);
        last_good = 8'h81;
        checks++; if (v_data.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", v_data.size()); end
        if (v_data.size() >= 1) begin
            checks++; if (v_data[0] !== 8'h81) begin errors++; $display("FAIL rstmid_newdata: got %h expected 81", v_data[0]); end
        end
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL rstmid_err_count: got %0d expected 0", e_cyc.size()); end
    endtask

    // Random bytes, random stop bits and random idle gaps against a frame-level model
    task test_random();
        logic [7:0] exp_q[$];
        int         exp_edge[$];
        int         exp_err;
        logic [7:0] b;
        logic       stop;
        int         t, gap;
        clear_mon();
        exp_err = 0;
        for (int n = 0; n < 16; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, t);
            if (stop) begin
                exp_q.push_back(b);
                exp_edge.push_back(t);
                last_good = b;
                gap = $urandom_range(0, 10);
            end else begin
                exp_err++;
                gap = $urandom_range(2, 10);
            end
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (3 * BIT) @(negedge clk);
        checks++; if (v_data.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", v_data.size(), exp_q.size()); end
        if (v_data.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (v_data[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, v_data[i], exp_q[i]); end
                checks++;
                if ((v_cyc[i] - exp_edge[i]) < LAT_MIN || (v_cyc[i] - exp_edge[i]) > LAT_MAX) begin
                    errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d..%0d", i, v_cyc[i] - exp_edge[i], LAT_MIN, LAT_MAX);
                end
            end
        end
        checks++; if (e_cyc.size() != exp_err) begin errors++; $display("FAIL rand_err_count: got %0d expected %0d", e_cyc.size(), exp_err); end
        checks++; if (rx_data !== last_good) begin errors++; $display("FAIL rand_last_data: got %h expected %h", rx_data, last_good); end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL rand_both: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
